// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_pkg
// Purpose  : Shared FSM encodings and byte constants for the SPI target.
// Revision : 1.0 - initial release
// ============================================================================
package spi_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int         CMD_WE_BIT      = 7;
    localparam logic [7:0] LATE_READ_BYTE  = 8'hFF;
    localparam logic [7:0] WRITE_FILL_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/spi_target_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_if
// Purpose  : Single-transfer register bus between the SPI target and the
//            register file.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_target_if;
    logic       cyc_o;
    logic       stb_o;
    logic       we_o;
    logic [6:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;

    modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i);
    modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i);
endinterface
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Purpose  : Synchronises SCK/SSEL/MOSI into clk_i and produces registered
//            rise/fall strobes for SCK and SSEL.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC = 2
) (
    input  wire  clk_i,
    input  wire  rst_i,
    input  wire  i_sck,
    input  wire  i_ssel,
    input  wire  i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ssel_rise,
    output logic o_ssel_fall,
    output logic o_ssel,
    output logic o_mosi
);

    logic [SYNC-1:0] r_sck_sync;
    logic [SYNC-1:0] r_ssel_sync;
    logic [SYNC-1:0] r_mosi_sync;
    logic            r_sck_prev;
    logic            r_ssel_prev;
    logic            r_sck_rise;
    logic            r_sck_fall;
    logic            r_ssel_rise;
    logic            r_ssel_fall;
    logic            w_sck;

    assign w_sck  = r_sck_sync[SYNC-1];
    assign o_ssel = r_ssel_sync[SYNC-1];
    assign o_mosi = r_mosi_sync[SYNC-1];

    // SSEL resets to its deasserted (high) level so reset never fakes a select
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_sync  <= '0;
            r_ssel_sync <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_ssel_prev <= 1'b1;
            r_sck_rise  <= 1'b0;
            r_sck_fall  <= 1'b0;
            r_ssel_rise <= 1'b0;
            r_ssel_fall <= 1'b0;
        end else begin
            r_sck_sync  <= (r_sck_sync  << 1) | SYNC'(i_sck);
            r_ssel_sync <= (r_ssel_sync << 1) | SYNC'(i_ssel);
            r_mosi_sync <= (r_mosi_sync << 1) | SYNC'(i_mosi);
            r_sck_prev  <= w_sck;
            r_ssel_prev <= o_ssel;
            r_sck_rise  <=  w_sck  & ~r_sck_prev;
            r_sck_fall  <= ~w_sck  &  r_sck_prev;
            r_ssel_rise <=  o_ssel & ~r_ssel_prev;
            r_ssel_fall <= ~o_ssel &  r_ssel_prev;
        end
    end

    assign o_sck_rise  = r_sck_rise;
    assign o_sck_fall  = r_sck_fall;
    assign o_ssel_rise = r_ssel_rise;
    assign o_ssel_fall = r_ssel_fall;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Purpose  : Oversampled SPI mode-0 slave that turns {we, adr} command bytes
//            plus data bytes into auto-incrementing register bus transfers.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = 8'hA7,
    parameter int         SYNC        = 2
) (
    input  wire               clk_i,
    input  wire               rst_i,
    input  wire               SCK,
    input  wire               SSEL,
    input  wire               MOSI,
    output logic              MISO,
    spi_target_if.master      bus,
    output logic              busy_o,
    output logic              err_o
);

    state_t     r_state;
    state_t     w_state_next;

    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_ssel_rise;
    logic       w_ssel_fall;
    logic       w_ssel;
    logic       w_mosi;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic       r_rd_discard;
    logic       r_boundary;
    logic       r_err;
    logic [6:0] r_adr;
    logic       r_cyc;
    logic       r_we;
    logic [6:0] r_bus_adr;
    logic [7:0] r_bus_dat;

    logic       w_active;
    logic       w_byte_done;
    logic [7:0] w_rx_byte;
    logic       w_rd_ack;
    logic [7:0] w_tx_next;
    logic       w_late;

    spi_pin_sync #(
        .SYNC (SYNC)
    ) u_pin_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_sck       (SCK),
        .i_ssel      (SSEL),
        .i_mosi      (MOSI),
        .o_sck_rise  (w_sck_rise),
        .o_sck_fall  (w_sck_fall),
        .o_ssel_rise (w_ssel_rise),
        .o_ssel_fall (w_ssel_fall),
        .o_ssel      (w_ssel),
        .o_mosi      (w_mosi)
    );

    assign w_active    = (r_state == ST_CMD) || (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_byte_done = w_active && w_sck_rise && !w_ssel_rise && (r_bit_cnt == 3'd7);
    assign w_rd_ack    = r_cyc && bus.ack_i && !r_we && !r_rd_discard;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = WRITE_FILL_BYTE;
        w_late       = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_ssel_fall) w_state_next = ST_CMD;
            ST_CMD: begin
                if (w_ssel_rise)      w_state_next = ST_DRAIN;
                else if (w_byte_done) w_state_next = w_rx_byte[CMD_WE_BIT] ? ST_WRITE : ST_READ;
            end
            ST_WRITE: if (w_ssel_rise) w_state_next = ST_DRAIN;
            ST_READ:  if (w_ssel_rise) w_state_next = ST_DRAIN;
            ST_DRAIN: if (!r_cyc) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        // A read acked in the same cycle as the boundary fall is still on time
        if (r_state == ST_READ) begin
            if (r_rd_valid)    w_tx_next = r_rd_data;
            else if (w_rd_ack) w_tx_next = bus.dat_i;
            else begin
                w_tx_next = LATE_READ_BYTE;
                w_late    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_discard <= 1'b0;
            r_boundary   <= 1'b0;
            r_err        <= 1'b0;
            r_adr        <= '0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_bus_adr    <= '0;
            r_bus_dat    <= '0;
        end else begin
            if (r_cyc && bus.ack_i) begin
                r_cyc <= 1'b0;
                if (!r_we) begin
                    if (r_rd_discard) r_rd_discard <= 1'b0;
                    else begin
                        r_rd_data  <= bus.dat_i;
                        r_rd_valid <= 1'b1;
                    end
                end
            end

            if (r_state == ST_IDLE && w_ssel_fall) begin
                r_tx_shift   <= HEADER_BYTE;
                r_err        <= 1'b0;
                r_bit_cnt    <= '0;
                r_boundary   <= 1'b0;
                r_rd_valid   <= 1'b0;
                r_rd_discard <= 1'b0;
            end

            if (r_state == ST_DRAIN) begin
                r_tx_shift <= '0;
                r_boundary <= 1'b0;
            end

            if (w_active && !w_ssel_rise) begin
                if (w_sck_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (w_sck_fall) begin
                    r_boundary <= 1'b0;
                    if (r_boundary) begin
                        r_tx_shift <= w_tx_next;
                        if (r_state == ST_READ) r_rd_valid <= 1'b0;
                        if (w_late) begin
                            r_err <= 1'b1;
                            if (r_cyc && !r_we) r_rd_discard <= 1'b1;
                        end
                    end else begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
            end

            // A new transfer is only issued onto an idle bus; otherwise it is an overrun
            if (w_byte_done) begin
                r_boundary <= 1'b1;
                case (r_state)
                    ST_CMD: begin
                        r_adr <= w_rx_byte[6:0];
                        if (!w_rx_byte[CMD_WE_BIT] && !r_cyc) begin
                            r_cyc      <= 1'b1;
                            r_we       <= 1'b0;
                            r_bus_adr  <= w_rx_byte[6:0];
                            r_rd_valid <= 1'b0;
                        end
                    end
                    ST_WRITE: begin
                        if (!r_cyc) begin
                            r_cyc     <= 1'b1;
                            r_we      <= 1'b1;
                            r_bus_adr <= r_adr;
                            r_bus_dat <= w_rx_byte;
                            r_adr     <= r_adr + 7'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (!r_cyc) begin
                            r_cyc      <= 1'b1;
                            r_we       <= 1'b0;
                            r_bus_adr  <= r_adr + 7'd1;
                            r_adr      <= r_adr + 7'd1;
                            r_rd_valid <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign MISO       = r_tx_shift[7];
    assign bus.cyc_o  = r_cyc;
    assign bus.stb_o  = r_cyc;
    assign bus.we_o   = r_we;
    assign bus.adr_o  = r_bus_adr;
    assign bus.dat_o  = r_bus_dat;
    assign busy_o     = ~w_ssel;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Purpose  : Directed self-checking bench for spi_target with a bus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    localparam int HALF = 10;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic SCK   = 1'b0;
    logic SSEL  = 1'b1;
    logic MOSI  = 1'b0;
    logic MISO;
    logic busy_o;
    logic err_o;

    spi_target_if bus ();

    spi_target u_dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .SCK    (SCK),
        .SSEL   (SSEL),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          log_n    = 0;
    logic [15:0] log_q [0:31];
    int          wait_cnt = 0;
    bit          ack_en   = 1'b1;
    int          ack_delay = 1;

    // Register-file model: read data = adr + 8'h40; each acked transfer logged as {we, adr, dat}
    always @(negedge clk_i) begin
        if (rst_i) begin
            bus.ack_i = 1'b0;
            bus.dat_i = 8'h00;
            wait_cnt  = 0;
        end else if (bus.ack_i) begin
            bus.ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (bus.stb_o) begin
            wait_cnt = wait_cnt + 1;
            if (ack_en && wait_cnt >= ack_delay) begin
                bus.ack_i = 1'b1;
                bus.dat_i = {1'b0, bus.adr_o} + 8'h40;
                if (log_n < 32) begin
                    log_q[log_n] = {bus.we_o, bus.adr_o, bus.we_o ? bus.dat_o : bus.dat_i};
                    log_n = log_n + 1;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            repeat (HALF) @(negedge clk_i);
            SCK   = 1'b1;
            rx[i] = MISO;
            repeat (HALF) @(negedge clk_i);
            SCK = 1'b0;
        end
    endtask

    task automatic spi_start();
        SSEL = 1'b0;
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic spi_stop();
        repeat (HALF) @(negedge clk_i);
        SSEL = 1'b1;
        repeat (3 * HALF) @(negedge clk_i);
    endtask

    initial begin
        logic [7:0] rx0, rx1, rx2;
        int         b;

        repeat (4) @(negedge clk_i);
        chk("reset_outputs", {MISO, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o, busy_o, err_o}, 32'h0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Write burst 85,11,22 -> 11@05, 22@06
        b = log_n;
        spi_start();
        chk("busy_in_txn", busy_o, 1'b1);
        spi_xfer(8'h85, 8, rx0);
        spi_xfer(8'h11, 8, rx1);
        spi_xfer(8'h22, 8, rx2);
        spi_stop();
        chk("wr_header", rx0, 8'hA7);
        chk("wr_fill", rx1, 8'h00);
        chk("wr_count", log_n - b, 2);
        chk("wr_0", log_q[b],     {1'b1, 7'h05, 8'h11});
        chk("wr_1", log_q[b + 1], {1'b1, 7'h06, 8'h22});
        chk("wr_err", err_o, 1'b0);
        chk("busy_after", busy_o, 1'b0);

        // Read burst from 0x10
        b = log_n;
        spi_start();
        spi_xfer(8'h10, 8, rx0);
        spi_xfer(8'h00, 8, rx1);
        spi_xfer(8'h00, 8, rx2);
        spi_stop();
        chk("rd_header", rx0, 8'hA7);
        chk("rd_byte1", rx1, 8'h50);
        chk("rd_byte2", rx2, 8'h51);
        chk("rd_count", log_n - b, 3);
        chk("rd_0", log_q[b],     {1'b0, 7'h10, 8'h50});
        chk("rd_1", log_q[b + 1], {1'b0, 7'h11, 8'h51});
        chk("rd_2", log_q[b + 2], {1'b0, 7'h12, 8'h52});
        chk("rd_err", err_o, 1'b0);

        // Address wrap 7F -> 00
        b = log_n;
        spi_start();
        spi_xfer(8'hFF, 8, rx0);
        spi_xfer(8'hAA, 8, rx1);
        spi_xfer(8'hBB, 8, rx2);
        spi_stop();
        chk("wrap_count", log_n - b, 2);
        chk("wrap_0", log_q[b],     {1'b1, 7'h7F, 8'hAA});
        chk("wrap_1", log_q[b + 1], {1'b1, 7'h00, 8'hBB});

        // Write overrun: second byte dropped, address not advanced
        b = log_n;
        ack_en = 1'b0;
        spi_start();
        spi_xfer(8'h85, 8, rx0);
        spi_xfer(8'h11, 8, rx1);
        spi_xfer(8'h22, 8, rx2);
        chk("ovr_err_set", err_o, 1'b1);
        ack_en = 1'b1;
        repeat (HALF) @(negedge clk_i);
        spi_xfer(8'h33, 8, rx2);
        spi_stop();
        chk("ovr_count", log_n - b, 2);
        chk("ovr_0", log_q[b],     {1'b1, 7'h05, 8'h11});
        chk("ovr_1", log_q[b + 1], {1'b1, 7'h06, 8'h33});
        chk("ovr_err_sticky", err_o, 1'b1);

        // Late read from 0x20: first data byte is FF, its late data discarded
        b = log_n;
        ack_delay = 25;
        spi_start();
        chk("err_cleared", err_o, 1'b0);
        spi_xfer(8'h20, 8, rx0);
        repeat (3 * HALF) @(negedge clk_i);
        ack_delay = 1;
        spi_xfer(8'h00, 8, rx1);
        spi_xfer(8'h00, 8, rx2);
        spi_stop();
        chk("late_byte", rx1, 8'hFF);
        chk("late_next", rx2, 8'h61);
        chk("late_err", err_o, 1'b1);
        chk("late_count", log_n - b, 3);
        chk("late_rd1", log_q[b + 1], {1'b0, 7'h21, 8'h61});

        // Abort after 4 bits of a data byte, then a clean write
        b = log_n;
        spi_start();
        spi_xfer(8'h85, 8, rx0);
        spi_xfer(8'hC3, 4, rx1);
        spi_stop();
        chk("abort_no_cycle", log_n - b, 0);
        chk("abort_idle", {busy_o, bus.cyc_o}, 2'b00);
        spi_start();
        spi_xfer(8'h83, 8, rx0);
        spi_xfer(8'h5A, 8, rx1);
        spi_stop();
        chk("post_abort_count", log_n - b, 1);
        chk("post_abort_wr", log_q[b], {1'b1, 7'h03, 8'h5A});

        // Reset while stb_o is held
        b = log_n;
        ack_en = 1'b0;
        spi_start();
        spi_xfer(8'h85, 8, rx0);
        spi_xfer(8'h77, 8, rx1);
        repeat (3) @(negedge clk_i);
        chk("stb_held", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}, {3'b111, 7'h05, 8'h77});
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mid_outputs", {MISO, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o, busy_o, err_o}, 32'h0);
        SSEL = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i  = 1'b0;
        ack_en = 1'b1;
        repeat (3 * HALF) @(negedge clk_i);
        chk("rst_abandoned", log_n - b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
